fp_rnd_pipe: RTL and testbench



---
 rtl/fp_rnd_pipe_pkg.sv | 57 +++++
 rtl/fp_rnd_pipe_if.sv | 17 +
 rtl/fp_rnd_pipe_pack.sv | 47 ++++
 rtl/fp_rnd_pipe.sv | 114 +++++++++++
 tb/tb_fp_rnd_pipe.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fp_rnd_pipe_pkg.sv
// Shared types for the binary32 rounder: producer record, stage registers,
// rounding-mode encodings, fflags bit positions and the canonical NaN.
package fp_wire;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [31:0] NAN_CANON = 32'h7FC0_0000;

    typedef struct packed {
        logic        sig;
        logic [10:0] expo;
        logic [24:0] mant;   // {carry, hidden, frac23}
        logic [1:0]  rema;
        logic [2:0]  grs;
        logic [2:0]  rm;
        logic        snan;
        logic        qnan;
        logic        dbz;
        logic        inf;
        logic        zero;
        logic        diff;
    } fp_rnd_in_type;

    typedef struct packed {
        logic        sig;
        logic [11:0] expo;   // one extra bit so the rounding carry never wraps
        logic [22:0] frac;
        logic [2:0]  rm;
        logic        nx;
        logic        snan;
        logic        qnan;
        logic        dbz;
        logic        inf;
        logic        zero;
        logic        diff;
    } fp_rnd_reg_type_1;

    localparam fp_rnd_reg_type_1 init_rnd_reg_1 = '0;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  flags;
    } fp_rnd_reg_type_2;

    localparam fp_rnd_reg_type_2 init_rnd_reg_2 = '0;

endpackage

// File: rtl/fp_rnd_pipe_if.sv
// Valid/ready record-in / result-out bundle of the binary32 rounder.
import fp_wire::*;

interface fp_rnd_pipe_if;
    logic          valid_i;
    logic          ready_o;
    fp_rnd_in_type rnd_i;
    logic          valid_o;
    logic          ready_i;
    logic [31:0]   result_o;
    logic [4:0]    fflags_o;

    modport slave  (input  valid_i, rnd_i, ready_i,
                    output ready_o, valid_o, result_o, fflags_o);
    modport master (output valid_i, rnd_i, ready_i,
                    input  ready_o, valid_o, result_o, fflags_o);
endinterface

// File: rtl/fp_rnd_pipe_pack.sv
// Stage-2 packer: special/overflow/finite selection and fflags generation.
import fp_wire::*;

module fp_rnd_pack (
    input  fp_rnd_reg_type_1 r_i,
    output fp_rnd_reg_type_2 p_o
);
    logic ovf;
    logic to_inf;
    logic uf;

    always_comb begin
        p_o    = init_rnd_reg_2;
        ovf    = (r_i.expo >= 12'd255);
        uf     = r_i.nx & (r_i.expo == 12'd0);
        to_inf = 1'b0;
        // Overflow saturates to max-finite whenever the mode rounds toward zero
        case (r_i.rm)
            RM_RNE, RM_RMM: to_inf = 1'b1;
            RM_RUP:         to_inf = ~r_i.sig;
            RM_RDN:         to_inf = r_i.sig;
            default:        to_inf = 1'b0;
        endcase

        if (r_i.snan) begin
            p_o.result          = NAN_CANON;
            p_o.flags[FLAG_NV]  = 1'b1;
        end else if (r_i.qnan) begin
            p_o.result          = NAN_CANON;
        end else if (r_i.dbz) begin
            p_o.result          = {r_i.sig, 8'hFF, 23'd0};
            p_o.flags[FLAG_DZ]  = 1'b1;
        end else if (r_i.inf) begin
            p_o.result          = {r_i.sig, 8'hFF, 23'd0};
        end else if (r_i.zero) begin
            p_o.result          = {(r_i.diff ? (r_i.rm == RM_RDN) : r_i.sig), 31'd0};
        end else if (ovf) begin
            p_o.result          = to_inf ? {r_i.sig, 8'hFF, 23'd0} : {r_i.sig, 31'h7F7F_FFFF};
            p_o.flags[FLAG_OF]  = 1'b1;
            p_o.flags[FLAG_NX]  = 1'b1;
        end else begin
            p_o.result          = {r_i.sig, r_i.expo[7:0], r_i.frac};
            p_o.flags[FLAG_UF]  = uf;
            p_o.flags[FLAG_NX]  = r_i.nx;
        end
    end
endmodule

// File: rtl/fp_rnd_pipe.sv
// Two-stage binary32 rounder/packer with valid/ready on both sides.
// Optional sticky fflags accumulator enabled by FP_RND_STICKY_EN.
import fp_wire::*;

module fp_rnd_pipe (
    input  logic          clock,
    input  logic          reset,
    fp_rnd_pipe_if.slave  bus,
    input  logic          flags_clr,
    output logic [4:0]    fflags_acc
);
    fp_rnd_reg_type_1 p1_d, p1_q;
    fp_rnd_reg_type_2 p2_d, p2_q;
    logic             vld_p1_q, vld_p2_q;
    logic             adv1, adv2;
    logic [24:0]      m_rnd;
    logic [11:0]      e_rnd;
    logic [1:0]       unused_rema;

    function automatic logic rnd_up_f(input logic [2:0] rm, input logic sig,
                                      input logic [2:0] grs, input logic lsb);
        case (rm)
            RM_RNE:  return grs[2] & (grs[1] | grs[0] | lsb);
            RM_RDN:  return sig & (|grs);
            RM_RUP:  return ~sig & (|grs);
            RM_RMM:  return grs[2];
            default: return 1'b0;
        endcase
    endfunction

    assign unused_rema = bus.rnd_i.rema;

    // Stage 1: round the mantissa and renormalise the exponent
    always_comb begin
        p1_d  = init_rnd_reg_1;
        m_rnd = bus.rnd_i.mant + {24'd0, rnd_up_f(bus.rnd_i.rm, bus.rnd_i.sig,
                                                  bus.rnd_i.grs, bus.rnd_i.mant[0])};
        e_rnd = {1'b0, bus.rnd_i.expo};
        if (m_rnd[24]) begin
            e_rnd = e_rnd + 12'd1;
            m_rnd = m_rnd >> 1;
        end
        if (e_rnd == 12'd0 && m_rnd[23]) e_rnd = 12'd1;
        p1_d.sig  = bus.rnd_i.sig;
        p1_d.expo = e_rnd;
        p1_d.frac = m_rnd[22:0];
        p1_d.rm   = bus.rnd_i.rm;
        p1_d.nx   = |bus.rnd_i.grs;
        p1_d.snan = bus.rnd_i.snan;
        p1_d.qnan = bus.rnd_i.qnan;
        p1_d.dbz  = bus.rnd_i.dbz;
        p1_d.inf  = bus.rnd_i.inf;
        p1_d.zero = bus.rnd_i.zero;
        p1_d.diff = bus.rnd_i.diff;
    end

    // Stage 2: pack and flag
    fp_rnd_pack u_pack (
        .r_i (p1_q),
        .p_o (p2_d)
    );

    assign adv2        = ~vld_p2_q | bus.ready_i;
    assign adv1        = ~vld_p1_q | adv2;
    assign bus.ready_o = adv1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            p1_q     <= init_rnd_reg_1;
            p2_q     <= init_rnd_reg_2;
        end else begin
            if (adv1) begin
                vld_p1_q <= bus.valid_i;
                if (bus.valid_i) p1_q <= p1_d;
            end
            if (adv2) begin
                vld_p2_q <= vld_p1_q;
                if (vld_p1_q) p2_q <= p2_d;
            end
        end
    end

    assign bus.valid_o  = vld_p2_q;
    assign bus.result_o = p2_q.result;
    assign bus.fflags_o = p2_q.flags;

`ifdef FP_RND_STICKY_EN
    logic [4:0] acc_d, acc_q;
    logic       fire;

    assign fire = vld_p2_q & bus.ready_i;

    // A clear coinciding with a delivered result keeps only that result's flags
    always_comb begin
        acc_d = acc_q;
        if (flags_clr)  acc_d = fire ? p2_q.flags : 5'd0;
        else if (fire)  acc_d = acc_q | p2_q.flags;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) acc_q <= 5'd0;
        else       acc_q <= acc_d;
    end

    assign fflags_acc = acc_q;
`else
    logic unused_clr;
    assign unused_clr = flags_clr;
    assign fflags_acc = 5'd0;
`endif

endmodule

// File: tb/tb_fp_rnd_pipe.sv
// Directed bench for fp_rnd_pipe: vector table, backpressure, reset, sticky flags.
import fp_wire::*;

module tb_fp_rnd_pipe;
    logic       clk;
    logic       rst;
    logic       flags_clr;
    logic [4:0] fflags_acc;
    int         checks;
    int         failures;

    fp_rnd_pipe_if bus ();

    fp_rnd_pipe dut (
        .clock      (clk),
        .reset      (rst),
        .bus        (bus),
        .flags_clr  (flags_clr),
        .fflags_acc (fflags_acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        string         name;
        fp_rnd_in_type in;
        logic [31:0]   res;
        logic [4:0]    fl;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic fp_rnd_in_type mk(input logic s, input logic [10:0] e,
                                         input logic [24:0] m, input logic [2:0] g,
                                         input logic [2:0] rm);
        fp_rnd_in_type r;
        r      = '0;
        r.sig  = s;
        r.expo = e;
        r.mant = m;
        r.grs  = g;
        r.rm   = rm;
        return r;
    endfunction

    task automatic add(input string nm, input fp_rnd_in_type in,
                       input logic [31:0] res, input logic [4:0] fl);
        vec_t v;
        v.name = nm;
        v.in   = in;
        v.res  = res;
        v.fl   = fl;
        vecs.push_back(v);
    endtask

    // Accept one record, check 2-cycle latency, leave result pending delivery
    task automatic send_one(input string nm, input fp_rnd_in_type rin,
                            input logic [31:0] er, input logic [4:0] ef);
        @(negedge clk);
        chk({nm, "_rdy"}, {31'd0, bus.ready_o}, 32'd1);
        bus.valid_i = 1'b1;
        bus.rnd_i   = rin;
        @(negedge clk);
        bus.valid_i = 1'b0;
        chk({nm, "_lat1"}, {31'd0, bus.valid_o}, 32'd0);
        @(negedge clk);
        chk({nm, "_vld"}, {31'd0, bus.valid_o}, 32'd1);
        chk({nm, "_res"}, bus.result_o, er);
        chk({nm, "_flg"}, {27'd0, bus.fflags_o}, {27'd0, ef});
    endtask

    initial begin
        fp_rnd_in_type t;
        fp_rnd_in_type bp[4];
        int sent, got;

        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        flags_clr   = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.rnd_i   = '0;

        add("rne_tie",   mk(0, 127, 25'h0800001, 3'b100, RM_RNE), 32'h3F80_0002, 5'h01);
        add("carry",     mk(0, 127, 25'h0FFFFFF, 3'b100, RM_RNE), 32'h4000_0000, 5'h01);
        add("subn_norm", mk(0,   0, 25'h07FFFFF, 3'b100, RM_RNE), 32'h0080_0000, 5'h01);
        add("ovf_rtz",   mk(0, 256, 25'h0800000, 3'b000, RM_RTZ), 32'h7F7F_FFFF, 5'h05);
        add("ovf_rdn",   mk(1, 256, 25'h0800000, 3'b000, RM_RDN), 32'hFF80_0000, 5'h05);
        add("ovf_rm5",   mk(0, 256, 25'h0800000, 3'b000, 3'd5),   32'h7F7F_FFFF, 5'h05);
        add("exact",     mk(1, 130, 25'h0C00000, 3'b000, RM_RNE), 32'hC140_0000, 5'h00);
        add("rtz_trunc", mk(0, 127, 25'h0800001, 3'b111, RM_RTZ), 32'h3F80_0001, 5'h01);
        add("rup_s",     mk(0, 127, 25'h0800001, 3'b001, RM_RUP), 32'h3F80_0002, 5'h01);
        add("rne_even",  mk(0, 127, 25'h0800002, 3'b100, RM_RNE), 32'h3F80_0002, 5'h01);
        add("rmm_neg",   mk(1, 127, 25'h0800000, 3'b100, RM_RMM), 32'hBF80_0001, 5'h01);
        add("uflow",     mk(0,   0, 25'h0000010, 3'b010, RM_RNE), 32'h0000_0010, 5'h03);
        t = mk(0, 0, 0, 0, RM_RNE); t.snan = 1'b1;
        add("snan", t, 32'h7FC0_0000, 5'h10);
        t = mk(0, 0, 0, 0, RM_RNE); t.qnan = 1'b1;
        add("qnan", t, 32'h7FC0_0000, 5'h00);
        t = mk(1, 0, 0, 0, RM_RNE); t.dbz = 1'b1;
        add("dbz", t, 32'hFF80_0000, 5'h08);
        t = mk(0, 0, 0, 0, RM_RNE); t.inf = 1'b1;
        add("inf", t, 32'h7F80_0000, 5'h00);
        t = mk(0, 0, 0, 0, RM_RDN); t.zero = 1'b1; t.diff = 1'b1;
        add("zero_diff_rdn", t, 32'h8000_0000, 5'h00);
        t = mk(1, 0, 0, 0, RM_RNE); t.zero = 1'b1;
        add("zero_neg", t, 32'h8000_0000, 5'h00);
        t = mk(0, 0, 0, 0, RM_RNE); t.snan = 1'b1; t.qnan = 1'b1; t.dbz = 1'b1;
        add("prio_snan", t, 32'h7FC0_0000, 5'h10);

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid_o", {31'd0, bus.valid_o}, 32'd0);
        chk("rst_ready_o", {31'd0, bus.ready_o}, 32'd1);
        chk("rst_result",  bus.result_o, 32'd0);
        chk("rst_fflags",  {27'd0, bus.fflags_o}, 32'd0);
        chk("rst_acc",     {27'd0, fflags_acc}, 32'd0);

        foreach (vecs[i]) send_one(vecs[i].name, vecs[i].in, vecs[i].res, vecs[i].fl);
        @(negedge clk);
        chk("drain_valid", {31'd0, bus.valid_o}, 32'd0);

        // Backpressure: ready_i low for the first three cycles
        for (int k = 0; k < 4; k++) bp[k] = mk(0, 127, 25'h0800000 + 25'(k + 1), 3'b000, RM_RNE);
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            bus.ready_i = (cyc >= 3);
            bus.valid_i = (sent < 4);
            if (sent < 4) bus.rnd_i = bp[sent];
            #1;
            if (cyc == 1) chk("bp_rdy_c1", {31'd0, bus.ready_o}, 32'd1);
            if (cyc == 2) begin
                chk("bp_rdy_drop", {31'd0, bus.ready_o}, 32'd0);
                chk("bp_hold_vld", {31'd0, bus.valid_o}, 32'd1);
                chk("bp_hold_res", bus.result_o, 32'h3F80_0001);
            end
            if (bus.valid_o && bus.ready_i) begin
                chk("bp_order", bus.result_o, 32'h3F80_0000 + 32'(got + 1));
                got++;
            end
            if (bus.valid_i && bus.ready_o) sent++;
        end
        chk("bp_delivered", 32'(got), 32'd4);
        chk("bp_sent", 32'(sent), 32'd4);
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_no_dup", {31'd0, bus.valid_o}, 32'd0);
        end

        // Reset mid-stream discards in-flight records
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.rnd_i   = bp[0];
        repeat (2) @(negedge clk);
        chk("mid_vld_before", {31'd0, bus.valid_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_vld", {31'd0, bus.valid_o}, 32'd0);
        chk("mid_rst_res", bus.result_o, 32'd0);
        chk("mid_rst_rdy", {31'd0, bus.ready_o}, 32'd1);
        bus.valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_discard", {31'd0, bus.valid_o}, 32'd0);
        end

        // Sticky accumulator
        send_one("stk_a", vecs[0].in, 32'h3F80_0002, 5'h01);
        send_one("stk_b", vecs[12].in, 32'h7FC0_0000, 5'h10);
        @(negedge clk);
`ifdef FP_RND_STICKY_EN
        chk("stk_acc", {27'd0, fflags_acc}, 32'h11);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        chk("stk_clr", {27'd0, fflags_acc}, 32'h00);
        send_one("stk_c", vecs[0].in, 32'h3F80_0002, 5'h01);
        @(negedge clk);
        chk("stk_acc_c", {27'd0, fflags_acc}, 32'h01);
        send_one("stk_d", vecs[14].in, 32'hFF80_0000, 5'h08);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        chk("stk_clr_fire", {27'd0, fflags_acc}, 32'h08);
`else
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        chk("stk_off_acc", {27'd0, fflags_acc}, 32'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
